// File: rtl/copad_match_sequencer.sv
// copad_match_sequencer
//
// Sequences one shared 8-window copad best-match encoder over the 16 copad
// candidates of a CLCT request. Two passes (windows 0-7, then 8-15) are merged
// into a single best match, and one result is returned per accepted request.
//
// Ports
//   clock, reset                 40 MHz clock, synchronous active-high reset
//   req_vld[1:0] / req_rdy[1:0]  request handshake, bit n = CLCTn
//   req_pri_n / req_xky_n        16 candidate priorities / GEM x-keys for CLCTn
//   req_cvld_n                   16 candidate valids for CLCTn
//   cfg_max_pri                  largest priority accepted as a match
//   enc_pri_in / enc_xky_in      8 windows driven to the external encoder
//   enc_pri_best/xky_best/win_best  combinational encoder answer
//   res_*                        result strobe and fields (held until next result)
//   cnt_nomatch                  saturating count of results with res_found=0
//
// State table
//   state | meaning
//   IDLE  | waiting for a request, req_rdy shows the arbitration winner
//   PASS0 | encoder looks at captured windows 0-7, partial winner registered
//   PASS1 | encoder looks at captured windows 8-15, merged into partial winner
//   DONE  | res_vld strobe, result fields latched, no-match counter updated

module copad_match_sequencer #(
  parameter int PRIB = 10,
  parameter int XKYB = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_vld,
  output logic [1:0]          req_rdy,
  input  logic [16*PRIB-1:0]  req_pri_0,
  input  logic [16*PRIB-1:0]  req_pri_1,
  input  logic [16*XKYB-1:0]  req_xky_0,
  input  logic [16*XKYB-1:0]  req_xky_1,
  input  logic [15:0]         req_cvld_0,
  input  logic [15:0]         req_cvld_1,
  input  logic [PRIB-1:0]     cfg_max_pri,
  output logic [8*PRIB-1:0]   enc_pri_in,
  output logic [8*XKYB-1:0]   enc_xky_in,
  input  logic [PRIB-1:0]     enc_pri_best,
  input  logic [XKYB-1:0]     enc_xky_best,
  input  logic [2:0]          enc_win_best,
  output logic                res_vld,
  output logic                res_tag,
  output logic                res_found,
  output logic [3:0]          res_win,
  output logic [PRIB-1:0]     res_pri,
  output logic [XKYB-1:0]     res_xky,
  output logic [15:0]         cnt_nomatch
);

  localparam logic [PRIB-1:0] PRI_NONE = {PRIB{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS0 = 2'd1,
    S_PASS1 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                tag_q, tag_d;
  logic [16*PRIB-1:0]  pri_q, pri_d;
  logic [16*XKYB-1:0]  xky_q, xky_d;
  logic [PRIB-1:0]     part_pri_q, part_pri_d;
  logic [XKYB-1:0]     part_xky_q, part_xky_d;
  logic [3:0]          part_win_q, part_win_d;
  logic                hold_tag_q, hold_tag_d;
  logic                hold_found_q, hold_found_d;
  logic [3:0]          hold_win_q, hold_win_d;
  logic [PRIB-1:0]     hold_pri_q, hold_pri_d;
  logic [XKYB-1:0]     hold_xky_q, hold_xky_d;
  logic [15:0]         cnt_nomatch_q, cnt_nomatch_d;

  logic [1:0]          grant;
  logic                found_live;
  logic                in_done;
  logic [16*PRIB-1:0]  sel_pri;
  logic [16*XKYB-1:0]  sel_xky;
  logic [15:0]         sel_cvld;

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req_vld)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign sel_pri  = grant[1] ? req_pri_1  : req_pri_0;
  assign sel_xky  = grant[1] ? req_xky_1  : req_xky_0;
  assign sel_cvld = grant[1] ? req_cvld_1 : req_cvld_0;

  assign found_live = (part_pri_q != PRI_NONE) && (part_pri_q <= cfg_max_pri);
  assign in_done    = (state_q == S_DONE);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    tag_d         = tag_q;
    pri_d         = pri_q;
    xky_d         = xky_q;
    part_pri_d    = part_pri_q;
    part_xky_d    = part_xky_q;
    part_win_d    = part_win_q;
    hold_tag_d    = hold_tag_q;
    hold_found_d  = hold_found_q;
    hold_win_d    = hold_win_q;
    hold_pri_d    = hold_pri_q;
    hold_xky_d    = hold_xky_q;
    cnt_nomatch_d = cnt_nomatch_q;
    req_rdy       = 2'b00;
    enc_pri_in    = {8*PRIB{1'b1}};
    enc_xky_in    = '0;
    res_vld       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Suppressed during reset so no handshake is seen while being cleared.
        req_rdy = reset ? 2'b00 : grant;
        if (grant != 2'b00) begin
          state_d = S_PASS0;
          ptr_d   = grant[1];
          tag_d   = grant[1];
          xky_d   = sel_xky;
          // Invalid candidates are turned into "no candidate" so the encoder
          // never has to look at the valid bits.
          for (int k = 0; k < 16; k++) begin
            pri_d[k*PRIB +: PRIB] = sel_cvld[k] ? sel_pri[k*PRIB +: PRIB] : PRI_NONE;
          end
        end
      end
      S_PASS0: begin
        enc_pri_in = pri_q[0 +: 8*PRIB];
        enc_xky_in = xky_q[0 +: 8*XKYB];
        part_pri_d = enc_pri_best;
        part_xky_d = enc_xky_best;
        part_win_d = {1'b0, enc_win_best};
        state_d    = S_PASS1;
      end
      S_PASS1: begin
        enc_pri_in = pri_q[8*PRIB +: 8*PRIB];
        enc_xky_in = xky_q[8*XKYB +: 8*XKYB];
        // Strictly-less keeps the lower window on a cross-pass tie.
        if (enc_pri_best < part_pri_q) begin
          part_pri_d = enc_pri_best;
          part_xky_d = enc_xky_best;
          part_win_d = {1'b1, enc_win_best};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        res_vld      = 1'b1;
        hold_tag_d   = tag_q;
        hold_found_d = found_live;
        hold_win_d   = part_win_q;
        hold_pri_d   = part_pri_q;
        hold_xky_d   = part_xky_q;
        if (!found_live && (cnt_nomatch_q != 16'hFFFF)) begin
          cnt_nomatch_d = cnt_nomatch_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The result is presented live during DONE and held from the latched copy
  // afterwards, so the partial registers are free for the next request.
  assign res_tag     = in_done ? tag_q      : hold_tag_q;
  assign res_found   = in_done ? found_live : hold_found_q;
  assign res_win     = in_done ? part_win_q : hold_win_q;
  assign res_pri     = in_done ? part_pri_q : hold_pri_q;
  assign res_xky     = in_done ? part_xky_q : hold_xky_q;
  assign cnt_nomatch = cnt_nomatch_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= 1'b1;
      tag_q         <= 1'b0;
      pri_q         <= {16*PRIB{1'b1}};
      xky_q         <= '0;
      part_pri_q    <= PRI_NONE;
      part_xky_q    <= '0;
      part_win_q    <= '0;
      hold_tag_q    <= 1'b0;
      hold_found_q  <= 1'b0;
      hold_win_q    <= '0;
      hold_pri_q    <= '0;
      hold_xky_q    <= '0;
      cnt_nomatch_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      tag_q         <= tag_d;
      pri_q         <= pri_d;
      xky_q         <= xky_d;
      part_pri_q    <= part_pri_d;
      part_xky_q    <= part_xky_d;
      part_win_q    <= part_win_d;
      hold_tag_q    <= hold_tag_d;
      hold_found_q  <= hold_found_d;
      hold_win_q    <= hold_win_d;
      hold_pri_q    <= hold_pri_d;
      hold_xky_q    <= hold_xky_d;
      cnt_nomatch_q <= cnt_nomatch_d;
    end
  end

endmodule

// File: tb/tb_copad_match_sequencer.sv
// Bench for copad_match_sequencer: directed requests, a behavioural 8-window
// encoder, and a result scoreboard fed at accept time and drained on res_vld.

module tb_copad_match_sequencer;

  localparam int PRIB = 10;
  localparam int XKYB = 10;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          req_vld = 2'b00;
  logic [1:0]          req_rdy;
  logic [16*PRIB-1:0]  req_pri_0, req_pri_1;
  logic [16*XKYB-1:0]  req_xky_0, req_xky_1;
  logic [15:0]         req_cvld_0, req_cvld_1;
  logic [PRIB-1:0]     cfg_max_pri = 10'd20;
  logic [8*PRIB-1:0]   enc_pri_in;
  logic [8*XKYB-1:0]   enc_xky_in;
  logic [PRIB-1:0]     enc_pri_best;
  logic [XKYB-1:0]     enc_xky_best;
  logic [2:0]          enc_win_best;
  logic                res_vld, res_tag, res_found;
  logic [3:0]          res_win;
  logic [PRIB-1:0]     res_pri;
  logic [XKYB-1:0]     res_xky;
  logic [15:0]         cnt_nomatch;

  copad_match_sequencer #(.PRIB(PRIB), .XKYB(XKYB)) dut (
    .clock(clock), .reset(reset),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_pri_0(req_pri_0), .req_pri_1(req_pri_1),
    .req_xky_0(req_xky_0), .req_xky_1(req_xky_1),
    .req_cvld_0(req_cvld_0), .req_cvld_1(req_cvld_1),
    .cfg_max_pri(cfg_max_pri),
    .enc_pri_in(enc_pri_in), .enc_xky_in(enc_xky_in),
    .enc_pri_best(enc_pri_best), .enc_xky_best(enc_xky_best),
    .enc_win_best(enc_win_best),
    .res_vld(res_vld), .res_tag(res_tag), .res_found(res_found),
    .res_win(res_win), .res_pri(res_pri), .res_xky(res_xky),
    .cnt_nomatch(cnt_nomatch)
  );

  always #5 clock = ~clock;

  // Behavioural encoder: minimum priority, lowest window on ties, window 0
  // when every priority is all-ones.
  always_comb begin
    enc_pri_best = enc_pri_in[0 +: PRIB];
    enc_xky_best = enc_xky_in[0 +: XKYB];
    enc_win_best = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (enc_pri_in[k*PRIB +: PRIB] < enc_pri_best) begin
        enc_pri_best = enc_pri_in[k*PRIB +: PRIB];
        enc_xky_best = enc_xky_in[k*XKYB +: XKYB];
        enc_win_best = 3'(k);
      end
    end
  end

  // Candidate tables; x-key of CLCTt window k is 200 + 100*t + k.
  logic [PRIB-1:0] pri_a [2][16];
  logic            cvld_a [2][16];

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      req_pri_0[k*PRIB +: PRIB] = pri_a[0][k];
      req_pri_1[k*PRIB +: PRIB] = pri_a[1][k];
      req_xky_0[k*XKYB +: XKYB] = XKYB'(200 + k);
      req_xky_1[k*XKYB +: XKYB] = XKYB'(300 + k);
      req_cvld_0[k] = cvld_a[0][k];
      req_cvld_1[k] = cvld_a[1][k];
    end
  end

  typedef struct {
    int tag; int found; int win; int pri; int xky; int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc_tag [64];
  int   acc_cyc [64];
  int   ex_found [2], ex_win [2], ex_pri [2], ex_xky [2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept observer: pushes the expected result for the granted requester.
  always @(negedge clock) begin
    logic [1:0] g;
    exp_t e;
    g = req_rdy & req_vld;
    if (g != 2'b00) begin
      chk("rdy_onehot", int'($onehot(g)), 1);
      chk("rdy_only_valid", int'(req_rdy), int'(g));
      e.tag   = int'(g[1]);
      e.found = ex_found[e.tag];
      e.win   = ex_win[e.tag];
      e.pri   = ex_pri[e.tag];
      e.xky   = ex_xky[e.tag];
      e.cyc   = cyc + 3;
      q.push_back(e);
      if (acc_cnt < 64) begin
        acc_tag[acc_cnt] = e.tag;
        acc_cyc[acc_cnt] = cyc;
      end
      acc_cnt++;
    end
  end

  // Result monitor.
  always @(negedge clock) begin
    exp_t e;
    if (res_vld) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_res_vld got=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("res_cycle", cyc, e.cyc);
        chk("res_tag", int'(res_tag), e.tag);
        chk("res_found", int'(res_found), e.found);
        chk("res_win", int'(res_win), e.win);
        chk("res_pri", int'(res_pri), e.pri);
        chk("res_xky", int'(res_xky), e.xky);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic fill(input int t, input int pri, input bit v);
    for (int k = 0; k < 16; k++) begin
      pri_a[t][k]  = PRIB'(pri);
      cvld_a[t][k] = v;
    end
  endtask

  task automatic set_exp(input int t, input int found, input int win, input int pri, input int xky);
    ex_found[t] = found;
    ex_win[t]   = win;
    ex_pri[t]   = pri;
    ex_xky[t]   = xky;
  endtask

  // Issue one request from CLCTt, wait for accept, let the result drain.
  task automatic run_req(input int t, input int exp_cnt);
    int n0;
    bit got;
    n0 = acc_cnt;
    got = 1'b0;
    req_vld[t] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (acc_cnt != n0) got = 1'b1;
    end
    req_vld[t] = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=none expected=accept tag %0d", t);
    end else begin
      tick(3);
      chk("result_drained", q.size(), 0);
      chk("cnt_nomatch", int'(cnt_nomatch), exp_cnt);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_rdy", int'(req_rdy), 0);
    chk("rst_res_vld", int'(res_vld), 0);
    chk("rst_res_tag", int'(res_tag), 0);
    chk("rst_res_found", int'(res_found), 0);
    chk("rst_res_win", int'(res_win), 0);
    chk("rst_res_pri", int'(res_pri), 0);
    chk("rst_res_xky", int'(res_xky), 0);
    chk("rst_cnt_nomatch", int'(cnt_nomatch), 0);
    chk("rst_enc_pri_ones", int'(enc_pri_in == {8*PRIB{1'b1}}), 1);
    chk("rst_enc_xky_zero", int'(enc_xky_in == '0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit done;
    fill(0, 50, 1'b1);
    fill(1, 50, 1'b1);
    set_exp(0, 0, 0, 0, 0);
    set_exp(1, 0, 0, 0, 0);
    tick(3);
    check_reset_outputs();
    reset = 1'b0;
    tick(1);

    // Single request: best is window 11 in the second pass.
    for (int k = 0; k < 16; k++) pri_a[0][k] = PRIB'(100 + k);
    pri_a[0][11] = 10'd5;
    set_exp(0, 1, 11, 5, 211);
    run_req(0, 0);

    // Cross-pass tie on windows 3 and 12: lower window wins.
    fill(0, 50, 1'b1);
    pri_a[0][3]  = 10'd7;
    pri_a[0][12] = 10'd7;
    set_exp(0, 1, 3, 7, 203);
    run_req(0, 0);

    // Tie inside pass 1 on windows 9 and 14.
    fill(0, 50, 1'b1);
    pri_a[0][9]  = 10'd7;
    pri_a[0][14] = 10'd7;
    set_exp(0, 1, 9, 7, 209);
    run_req(0, 0);

    // No valid candidate at all.
    fill(0, 50, 1'b0);
    set_exp(0, 0, 0, 10'h3FF, 200);
    run_req(0, 1);

    // Best priority 30 exceeds cfg_max_pri 20.
    fill(0, 40, 1'b1);
    pri_a[0][6] = 10'd30;
    set_exp(0, 0, 6, 30, 206);
    run_req(0, 2);

    // Arbitration with both requesters held from reset.
    fill(0, 60, 1'b1);
    pri_a[0][2] = 10'd10;
    fill(1, 60, 1'b1);
    pri_a[1][13] = 10'd12;
    set_exp(0, 1, 2, 10, 202);
    set_exp(1, 1, 13, 12, 313);
    reset = 1'b1;
    req_vld = 2'b11;
    tick(2);
    reset = 1'b0;
    n0 = acc_cnt;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick(1);
      if (acc_cnt >= n0 + 3) done = 1'b1;
    end
    req_vld = 2'b00;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL arb_accepts got=%0d expected=3", acc_cnt - n0);
    end else begin
      tick(3);
      chk("arb_tag0", acc_tag[n0], 0);
      chk("arb_tag1", acc_tag[n0+1], 1);
      chk("arb_tag2", acc_tag[n0+2], 0);
      chk("arb_gap01", acc_cyc[n0+1] - acc_cyc[n0], 4);
      chk("arb_gap12", acc_cyc[n0+2] - acc_cyc[n0+1], 4);
      chk("arb_drained", q.size(), 0);
      chk("arb_cnt", int'(cnt_nomatch), 0);
    end

    // CLCT1 alone with no valid candidates.
    fill(1, 60, 1'b0);
    set_exp(1, 0, 0, 10'h3FF, 300);
    run_req(1, 1);

    // Reset asserted while in PASS1: no result, everything back to reset values.
    fill(1, 60, 1'b1);
    pri_a[1][13] = 10'd12;
    set_exp(1, 1, 13, 12, 313);
    n0 = acc_cnt;
    req_vld[1] = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(1);
      if (acc_cnt != n0) done = 1'b1;
    end
    req_vld = 2'b00;
    chk("rstmid_accepted", int'(done), 1);
    tick(1);
    reset = 1'b1;
    q.delete();
    tick(1);
    reset = 1'b0;
    check_reset_outputs();
    tick(4);
    chk("rstmid_no_result", q.size(), 0);

    // A fresh request completes normally afterwards.
    fill(0, 80, 1'b1);
    pri_a[0][15] = 10'd1;
    set_exp(0, 1, 15, 1, 215);
    run_req(0, 0);

    // No-match counter saturation.
    force dut.cnt_nomatch_q = 16'hFFFE;
    #1;
    release dut.cnt_nomatch_q;
    chk("sat_preload", int'(cnt_nomatch), 16'hFFFE);
    fill(0, 50, 1'b0);
    set_exp(0, 0, 0, 10'h3FF, 200);
    run_req(0, 16'hFFFF);
    run_req(0, 16'hFFFF);
    run_req(0, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/copad_match_sequencer.md
# copad_match_sequencer

Controller for the combinational 8-window CLCT–GEM copad best-match encoder. It arbitrates between the two CLCT requesters (CLCT0, CLCT1), each presenting 16 copad candidates, and runs the shared encoder twice per request, on windows 0–7 and then 8–15. It merges the two partial winners and returns one registered best match per request. It sits between CLCT/GEM copad matching and the ALCT–CLCT–GEM match logic.

## Interface
- PRIB, 10, width of bending-angle priority; all-ones means "no candidate".
- XKYB, 10, width of GEM x-key field.
- clock  in  1  main 40 MHz clock.
- reset  in  1  synchronous, active-high.
- req_vld  in  2  request valid, bit n = CLCTn.
- req_rdy  out  2  request accepted when req_vld[n] & req_rdy[n].
- req_pri_0 / req_pri_1  in  16*PRIB  candidate bend angles for CLCTn; window k at [PRIB*k +: PRIB].
- req_xky_0 / req_xky_1  in  16*XKYB  candidate GEM x-key for CLCTn.
- req_cvld_0 / req_cvld_1  in  16  candidate valid for CLCTn.
- cfg_max_pri  in  PRIB  largest priority accepted as a match.
- enc_pri_in  out  8*PRIB  priorities driven to the encoder.
- enc_xky_in  out  8*XKYB  x-keys driven to the encoder.
- enc_pri_best  in  PRIB  encoder winning priority (combinational).
- enc_xky_best  in  XKYB  encoder winning x-key.
- enc_win_best  in  3  encoder winning window 0–7.
- res_vld  out  1  one-cycle result strobe.
- res_tag  out  1  requester of this result.
- res_found  out  1  a valid candidate with priority <= cfg_max_pri exists.
- res_win  out  4  winning window 0–15.
- res_pri  out  PRIB  winning priority.
- res_xky  out  XKYB  winning x-key.
- cnt_nomatch  out  16  saturating count of results with res_found=0.

## Operation
- FSM states: IDLE, PASS0, PASS1, DONE.
  - IDLE -> PASS0 on accept.
  - PASS0 -> PASS1 unconditionally.
  - PASS1 -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- req_rdy is nonzero only in IDLE.
  - At most one bit is set: the arbitration winner among the asserted req_vld bits.
  - req_rdy is 2'b00 in IDLE when no request is present.
- Arbitration is round-robin.
  - A last-served pointer gives the other requester priority on simultaneous requests.
  - The pointer resets to 1, so CLCT0 wins the first tie.
  - The pointer updates on accept only.
- On accept, the winner's pri/xky/cvld buses and tag are captured into internal registers.
  - Masked priority: a candidate with cvld=0 has priority all-ones.
- enc_pri_in / enc_xky_in select captured windows 0–7 in PASS0 and windows 8–15 in PASS1.
  - In any other state they are driven all-ones / zero.
- PASS0 end: register partial = {enc_pri_best, enc_xky_best, 1'b0, enc_win_best}.
- PASS1 end: replace partial with {enc_pri_best, enc_xky_best, 1'b1, enc_win_best} only if enc_pri_best < partial priority (strictly less).
  - Ties keep the lower window.
- DONE: res_vld=1 with res_tag, res_win, res_pri and res_xky from partial.
  - res_found = (res_pri != all-ones) && (res_pri <= cfg_max_pri).
  - cfg_max_pri is sampled in DONE.
  - res_found=0 increments cnt_nomatch, saturating at 16'hFFFF.
- All candidates invalid: the encoder returns window 0 of each pass.
  - Result is res_found=0, res_win=0, res_pri=all-ones.
- Result fields hold their value after DONE until the next DONE. res_vld has no backpressure.
- Reset (any state, including mid-request): FSM to IDLE, in-flight request discarded, no res_vld.
  - All outputs 0, except enc_pri_in all-ones; cnt_nomatch cleared; pointer = 1.

## Timing
- Accept at cycle T (IDLE). PASS0 at T+1, PASS1 at T+2, DONE (res_vld=1) at T+3, IDLE at T+4.
- Latency is 3 cycles from accept to res_vld. Throughput is one request per 4 cycles.
- The encoder path is combinational within one cycle: captured registers -> enc_*_in -> encoder -> partial register.
- Request inputs are sampled only on the accept edge; later changes have no effect.
- A requester whose req_vld is held during a busy period is accepted at the next IDLE if it wins arbitration.

## Test plan
- Single request:
  - Stimulus: CLCT0, all 16 valid, pri = 100+k except window 11 = 5, cfg_max_pri=20.
  - Response: res_vld at T+3, tag 0, win 11, pri 5, found 1.
- Tie across passes:
  - Stimulus: windows 3 and 12 both pri 7, others 50.
  - Response: res_win=3.
  - Same stimulus, tie within pass 1 on windows 9 and 14: res_win=9.
- No match:
  - Stimulus 1: all cvld=0. Response: found 0, pri 3FF, win 0, cnt_nomatch=1.
  - Stimulus 2: best pri 30 with cfg_max_pri=20. Response: found 0, pri 30, cnt_nomatch=2.
- Arbitration:
  - Stimulus: req_vld=2'b11 held from reset.
  - Response: serves CLCT0, CLCT1, CLCT0 with res_vld at T+3, T+7, T+11; req_rdy is one-hot and only in IDLE.
- Reset mid-operation:
  - Stimulus: assert reset in PASS1.
  - Response: no res_vld; next cycle all outputs at reset values; a new request afterward completes normally in 3 cycles.
- Saturation:
  - Stimulus: force cnt_nomatch to FFFE, issue 3 no-match requests.
  - Response: count reads FFFF and holds.
